// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
//
// Purpose : Shared definitions for the 4-bit shift-register serial link.
//           The default word width is shared with the transmit end (piso) so
//           both ends of the link agree on word size without extra wiring.
//
// Contents:
//   SIPO_DEFAULT_WIDTH - default bits per word for both link ends
//   sipo_state_e       - receiver state: IDLE (no partial word) or SHIFT
// -----------------------------------------------------------------------------
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 4;

    // IDLE  : bit count 0, no partial word held.
    // SHIFT : 1..WIDTH-1 bits of the current word captured.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_e;

endpackage : sipo_pkg

// File: rtl/sipo.sv
// -----------------------------------------------------------------------------
// sipo
//
// Purpose : Serial-in, parallel-out deserializer. Samples one serial bit per
//           clock while sin_en is high, assembles WIDTH bits into a word and
//           presents each completed word in a one-entry registered output slot
//           with a valid/ready handshake. A word that completes while the slot
//           is still occupied and not being consumed is dropped and reported
//           with a one-cycle overrun pulse.
//
// Parameters:
//   WIDTH     - bits per word, 2..32
//   MSB_FIRST - 1: first received bit lands in pout[WIDTH-1]
//               0: first received bit lands in pout[0]
//
// Ports:
//   clk        in   single clock, all logic on the rising edge
//   rst        in   synchronous active-high reset, highest priority
//   sin_en     in   shift enable; sin is sampled on every edge where it is 1
//   sin        in   serial data bit
//   pout       out  last completed word (registered, held after consume)
//   pout_valid out  pout holds an unconsumed word
//   pout_ready in   consumer accepts pout when pout_valid && pout_ready
//   overrun    out  one-cycle pulse: a completed word was dropped
// -----------------------------------------------------------------------------
module sipo
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_en,
    input  logic             sin,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             overrun
);

    // One extra bit of headroom over what 0..WIDTH-1 strictly needs.
    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    sipo_state_e        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_pout;
    logic               r_pout_valid;
    logic               r_overrun;

    // -------------------------------------------------------------------------
    // Next-word datapath and slot decisions
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_next_shift;
    logic               w_word_done;
    logic               w_slot_free;
    logic               w_handshake;
    logic               w_load;
    logic               w_drop;

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        w_base       = r_shift;
        w_next_shift = r_shift;

        // A new word always starts from a clean register, so leftover bits
        // from an aborted or completed word can never leak into it.
        if (r_state == IDLE) begin
            w_base = '0;
        end

        if (MSB_FIRST) begin
            w_next_shift = {w_base[WIDTH-2:0], sin};
        end else begin
            w_next_shift = {sin, w_base[WIDTH-1:1]};
        end
    end

    // The edge that samples bit WIDTH of the current word.
    assign w_word_done = sin_en && (r_state == SHIFT) && (r_cnt == LAST_CNT);

    // The slot may be refilled if empty or if it is being consumed this edge.
    assign w_handshake = r_pout_valid && pout_ready;
    assign w_slot_free = !r_pout_valid || pout_ready;
    assign w_load      = w_word_done && w_slot_free;
    assign w_drop      = w_word_done && !w_slot_free;

    // -------------------------------------------------------------------------
    // FSM, counter, shift register and output slot
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_pout       <= '0;
            r_pout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Registered, so the pulse appears in the cycle after the drop
            // and lasts exactly one cycle.
            r_overrun <= w_drop;

            case (r_state)
                IDLE: begin
                    if (sin_en) begin
                        r_state <= SHIFT;
                        r_cnt   <= CNT_ONE;
                        r_shift <= w_next_shift;
                    end
                end

                SHIFT: begin
                    if (!sin_en) begin
                        // Enable dropped mid-word: discard the partial word.
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        // Word complete. Returning to IDLE lets the next bit
                        // start a fresh word on the very next edge.
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_shift <= w_next_shift;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                        r_shift <= w_next_shift;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_shift <= '0;
                end
            endcase

            // Output slot. pout is only ever written by a load; a consume
            // clears valid but leaves the data in place.
            if (w_load) begin
                r_pout       <= w_next_shift;
                r_pout_valid <= 1'b1;
            end else if (w_handshake) begin
                r_pout_valid <= 1'b0;
            end
        end
    end

    assign pout       = r_pout;
    assign pout_valid = r_pout_valid;
    assign overrun    = r_overrun;

endmodule : sipo

// File: tb/tb_sipo.sv
// -----------------------------------------------------------------------------
// tb_sipo
//
// Drives two sipo instances (WIDTH=4, MSB-first and LSB-first) with identical
// serial streams. Expected words are pushed to a scoreboard when a word is
// sent and popped when the DUTs present it.
// -----------------------------------------------------------------------------
module tb_sipo;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         sin_en;
    logic         sin;
    logic         pout_ready;

    logic [W-1:0] pout_m;
    logic         valid_m;
    logic         ovr_m;
    logic [W-1:0] pout_l;
    logic         valid_l;
    logic         ovr_l;

    int           tests_run;
    int           tests_failed;

    logic [W-1:0] q_m[$];
    logic [W-1:0] q_l[$];
    logic [W-1:0] last_m;
    logic [W-1:0] last_l;

    sipo #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .sin_en     (sin_en),
        .sin        (sin),
        .pout       (pout_m),
        .pout_valid (valid_m),
        .pout_ready (pout_ready),
        .overrun    (ovr_m)
    );

    sipo #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .sin_en     (sin_en),
        .sin        (sin),
        .pout       (pout_l),
        .pout_valid (valid_l),
        .pout_ready (pout_ready),
        .overrun    (ovr_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit order reversal: the LSB-first receiver puts the first bit in [0].
    function automatic logic [W-1:0] rev4(input logic [W-1:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // w is written in send order (w[3] sent first).
    task automatic push_exp(input logic [W-1:0] w);
        q_m.push_back(w);
        q_l.push_back(rev4(w));
    endtask

    task automatic check_status(input string tag, input logic exp_valid, input logic exp_ovr);
        check({tag, " valid_m"}, 32'(valid_m), 32'(exp_valid));
        check({tag, " valid_l"}, 32'(valid_l), 32'(exp_valid));
        check({tag, " ovr_m"},   32'(ovr_m),   32'(exp_ovr));
        check({tag, " ovr_l"},   32'(ovr_l),   32'(exp_ovr));
    endtask

    task automatic check_pout(input string tag, input logic [W-1:0] em, input logic [W-1:0] el);
        check({tag, " pout_m"}, 32'(pout_m), 32'(em));
        check({tag, " pout_l"}, 32'(pout_l), 32'(el));
    endtask

    // Pop the next expected word and compare it with both DUTs.
    task automatic expect_word(input string tag);
        check({tag, " scoreboard_nonempty"}, 32'(q_m.size() != 0), 32'd1);
        if (q_m.size() != 0 && q_l.size() != 0) begin
            last_m = q_m.pop_front();
            last_l = q_l.pop_front();
            check_pout(tag, last_m, last_l);
        end
    endtask

    task automatic send_bit(input logic en, input logic b);
        sin_en = en;
        sin    = b;
        tick();
    endtask

    // Sends w[3], w[2], w[1] checking the slot after each, then w[0] with
    // pout_ready set to last_ready; the caller checks the final edge.
    task automatic shift4(input string tag, input logic [W-1:0] w,
                          input logic mid_valid, input logic last_ready);
        for (int i = W - 1; i >= 1; i--) begin
            send_bit(1'b1, w[i]);
            check_status($sformatf("%s bit%0d", tag, W - i), mid_valid, 1'b0);
        end
        pout_ready = last_ready;
        send_bit(1'b1, w[0]);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        last_m       = '0;
        last_l       = '0;

        // Reset has priority even with a complete-looking stream on the pins.
        rst        = 1'b1;
        sin_en     = 1'b1;
        sin        = 1'b1;
        pout_ready = 1'b0;
        tick();
        tick();
        check_status("reset", 1'b0, 1'b0);
        check_pout("reset", 4'b0000, 4'b0000);

        rst    = 1'b0;
        sin_en = 1'b0;
        sin    = 1'b0;
        tick();
        check_status("post_reset_idle", 1'b0, 1'b0);

        // Basic word, consumer always ready: valid for exactly one cycle.
        pout_ready = 1'b1;
        push_exp(4'b1001);
        shift4("basic", 4'b1001, 1'b0, 1'b1);
        check_status("basic done", 1'b1, 1'b0);
        expect_word("basic");
        send_bit(1'b0, 1'b0);
        check_status("basic consumed", 1'b0, 1'b0);
        check_pout("basic held", last_m, last_l);

        // Back-to-back: no gap cycle, counter wraps cleanly.
        push_exp(4'b1001);
        push_exp(4'b1100);
        shift4("b2b w0", 4'b1001, 1'b0, 1'b1);
        check_status("b2b w0 done", 1'b1, 1'b0);
        expect_word("b2b w0");
        shift4("b2b w1", 4'b1100, 1'b0, 1'b1);
        check_status("b2b w1 done", 1'b1, 1'b0);
        expect_word("b2b w1");
        send_bit(1'b0, 1'b0);
        check_status("b2b consumed", 1'b0, 1'b0);

        // Abort: two bits then enable low discards the partial word.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        check_status("abort partial", 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        check_status("abort gap", 1'b0, 1'b0);
        push_exp(4'b0110);
        shift4("abort word", 4'b0110, 1'b0, 1'b1);
        check_status("abort word done", 1'b1, 1'b0);
        expect_word("abort word");
        send_bit(1'b0, 1'b0);
        check_status("abort consumed", 1'b0, 1'b0);

        // Backpressure: second word dropped, one overrun pulse.
        pout_ready = 1'b0;
        push_exp(4'b1001);
        shift4("bp w0", 4'b1001, 1'b0, 1'b0);
        check_status("bp w0 done", 1'b1, 1'b0);
        expect_word("bp w0");
        shift4("bp w1", 4'b1100, 1'b1, 1'b0);
        check_status("bp w1 dropped", 1'b1, 1'b1);
        check_pout("bp w1 dropped", last_m, last_l);
        send_bit(1'b0, 1'b0);
        check_status("bp pulse end", 1'b1, 1'b0);
        pout_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        check_status("bp drained", 1'b0, 1'b0);
        check_pout("bp drained held", last_m, last_l);

        // Same-edge handshake and completion: new word loads, valid stays.
        pout_ready = 1'b0;
        push_exp(4'b1001);
        shift4("same w0", 4'b1001, 1'b0, 1'b0);
        check_status("same w0 done", 1'b1, 1'b0);
        expect_word("same w0");
        push_exp(4'b0011);
        shift4("same w1", 4'b0011, 1'b1, 1'b1);
        check_status("same w1 done", 1'b1, 1'b0);
        expect_word("same w1");
        send_bit(1'b0, 1'b0);
        check_status("same consumed", 1'b0, 1'b0);

        // Reset with a word pending and a word about to overrun.
        pout_ready = 1'b0;
        push_exp(4'b1111);
        shift4("rst pending", 4'b1111, 1'b0, 1'b0);
        check_status("rst pending done", 1'b1, 1'b0);
        expect_word("rst pending");
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        check_status("rst midword", 1'b1, 1'b0);
        rst = 1'b1;
        send_bit(1'b1, 1'b1);
        check_status("rst applied", 1'b0, 1'b0);
        check_pout("rst applied", 4'b0000, 4'b0000);
        rst = 1'b0;
        send_bit(1'b0, 1'b0);
        check_status("rst released", 1'b0, 1'b0);
        pout_ready = 1'b1;
        push_exp(4'b1010);
        shift4("rst word", 4'b1010, 1'b0, 1'b1);
        check_status("rst word done", 1'b1, 1'b0);
        expect_word("rst word");
        send_bit(1'b0, 1'b0);
        check_status("rst word consumed", 1'b0, 1'b0);

        check("scoreboard_drained", 32'(q_m.size() + q_l.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_sipo
